// File: rtl/pipe_controller_if.sv
// Decode-field and control-bundle bus between the datapath and the pipeline controller.
// master = datapath (drives ID decode fields and the EX redirect); slave = controller.
interface pipe_controller_if #(
  parameter int REG_AW = 5
);
  // ID-stage decode fields and EX redirect, from the datapath
  logic [6:0]        id_op;
  logic [2:0]        id_funct3;
  logic              id_funct7;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              ex_pc_src;

  // stage controls back to the datapath
  logic [2:0]        id_imm_src;
  logic [2:0]        ex_alu_ctrl;
  logic              ex_alu_src;
  logic              ex_unsigned;
  logic              ex_lui;
  logic [1:0]        ex_branch;
  logic [1:0]        ex_jump;
  logic              mem_mem_write;
  logic              wb_reg_write;
  logic [1:0]        wb_result_src;
  logic [REG_AW-1:0] wb_rd;

  // forwarding selects and hazard controls
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;

  modport master (
    output id_op, id_funct3, id_funct7, id_rs1, id_rs2, id_rd, ex_pc_src,
    input  id_imm_src, ex_alu_ctrl, ex_alu_src, ex_unsigned, ex_lui, ex_branch, ex_jump,
           mem_mem_write, wb_reg_write, wb_result_src, wb_rd,
           fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e
  );

  modport slave (
    input  id_op, id_funct3, id_funct7, id_rs1, id_rs2, id_rd, ex_pc_src,
    output id_imm_src, ex_alu_ctrl, ex_alu_src, ex_unsigned, ex_lui, ex_branch, ex_jump,
           mem_mem_write, wb_reg_write, wb_result_src, wb_rd,
           fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e
  );
endinterface

// File: rtl/pipe_controller.sv
// Pipeline controller: decodes the ID-stage instruction, carries its control
// bundle through ID/EX, EX/MEM and MEM/WB, and resolves RAW and control hazards
// with EX forwarding (FWD_EN=1) or pure stalling (FWD_EN=0).
module pipe_controller #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_controller_if.slave pc
);

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;   // 00 ALU, 01 load data, 10 pc+4
    logic       mem_write;
    logic [1:0] jump;         // 01 jal, 10 jalr
    logic [1:0] branch;       // 01 eq/ne compare, 10 lt/ge compare
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       is_unsigned;
    logic       lui;
  } ctrl_t;

  ctrl_t             dec;
  logic [2:0]        imm_src;
  logic [1:0]        alu_op;
  logic              is_br;

  ctrl_t             ex_c;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              mem_rw, mem_mw;
  logic [1:0]        mem_rs;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_rw;
  logic [1:0]        wb_rs;
  logic [REG_AW-1:0] wb_rd_q;

  logic              hit_ex, hit_mem, hit_wb, hazard;

  // main, ALU, unsigned and branch decoders for the ID-stage instruction
  always_comb begin
    dec     = '0;
    imm_src = 3'b000;
    alu_op  = 2'b00;
    is_br   = 1'b0;
    case (pc.id_op)
      7'b0000011: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b01; end
      7'b0100011: begin imm_src = 3'b001; dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
      7'b0110011: begin dec.reg_write = 1'b1; alu_op = 2'b10; end
      7'b0010011: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; alu_op = 2'b10; end
      7'b1100011: begin imm_src = 3'b010; alu_op = 2'b01; is_br = 1'b1; end
      7'b1101111: begin imm_src = 3'b011; dec.reg_write = 1'b1; dec.result_src = 2'b10; dec.jump = 2'b01; end
      7'b1100111: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b10; dec.jump = 2'b10; end
      7'b0110111: begin imm_src = 3'b100; dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.lui = 1'b1; end
      default: ;
    endcase
    case (alu_op)
      2'b01: dec.alu_ctrl = 3'b001;
      2'b10: begin
        case (pc.id_funct3)
          3'b000:  dec.alu_ctrl = (pc.id_op[5] & pc.id_funct7) ? 3'b001 : 3'b000;
          3'b001:  dec.alu_ctrl = 3'b110;
          3'b010,
          3'b011:  dec.alu_ctrl = 3'b101;
          3'b100:  dec.alu_ctrl = 3'b100;
          3'b101:  dec.alu_ctrl = 3'b111;
          3'b110:  dec.alu_ctrl = 3'b011;
          default: dec.alu_ctrl = 3'b010;
        endcase
      end
      default: dec.alu_ctrl = 3'b000;
    endcase
    dec.is_unsigned = ((alu_op == 2'b10) && (pc.id_funct3 == 3'b011)) ||
                      (is_br && (pc.id_funct3[2:1] == 2'b11));
    dec.branch      = is_br ? (pc.id_funct3[2] ? 2'b10 : 2'b01) : 2'b00;
  end

  // RAW detection against the ID sources; x0 never matches
  always_comb begin
    hit_ex  = (ex_rd   != '0) && ((ex_rd   == pc.id_rs1) || (ex_rd   == pc.id_rs2));
    hit_mem = (mem_rd  != '0) && ((mem_rd  == pc.id_rs1) || (mem_rd  == pc.id_rs2));
    hit_wb  = (wb_rd_q != '0) && ((wb_rd_q == pc.id_rs1) || (wb_rd_q == pc.id_rs2));
    if (FWD_EN)
      hazard = (ex_c.result_src == 2'b01) && hit_ex;
    else
      hazard = (ex_c.reg_write & hit_ex) | (mem_rw & hit_mem) | (wb_rw & hit_wb);
  end

  // a redirect squashes the stalled instruction anyway, so it overrides the stall
  assign pc.stall_f = hazard & ~pc.ex_pc_src;
  assign pc.stall_d = hazard & ~pc.ex_pc_src;
  assign pc.flush_d = pc.ex_pc_src;
  assign pc.flush_e = hazard | pc.ex_pc_src;

  // ID/EX takes a bubble on flush_e; EX/MEM and MEM/WB always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_c    <= '0;
      ex_rs1  <= '0;
      ex_rs2  <= '0;
      ex_rd   <= '0;
      mem_rw  <= 1'b0;
      mem_mw  <= 1'b0;
      mem_rs  <= 2'b00;
      mem_rd  <= '0;
      wb_rw   <= 1'b0;
      wb_rs   <= 2'b00;
      wb_rd_q <= '0;
    end else begin
      ex_c    <= pc.flush_e ? '0 : dec;
      ex_rs1  <= pc.flush_e ? '0 : pc.id_rs1;
      ex_rs2  <= pc.flush_e ? '0 : pc.id_rs2;
      ex_rd   <= pc.flush_e ? '0 : pc.id_rd;
      mem_rw  <= ex_c.reg_write;
      mem_mw  <= ex_c.mem_write;
      mem_rs  <= ex_c.result_src;
      mem_rd  <= ex_rd;
      wb_rw   <= mem_rw;
      wb_rs   <= mem_rs;
      wb_rd_q <= mem_rd;
    end
  end

  // EX operand select: MEM result beats WB result
  always_comb begin
    pc.fwd_a = 2'b00;
    pc.fwd_b = 2'b00;
    if (FWD_EN) begin
      if (mem_rw && (mem_rd != '0) && (mem_rd == ex_rs1))       pc.fwd_a = 2'b10;
      else if (wb_rw && (wb_rd_q != '0) && (wb_rd_q == ex_rs1)) pc.fwd_a = 2'b01;
      if (mem_rw && (mem_rd != '0) && (mem_rd == ex_rs2))       pc.fwd_b = 2'b10;
      else if (wb_rw && (wb_rd_q != '0) && (wb_rd_q == ex_rs2)) pc.fwd_b = 2'b01;
    end
  end

  assign pc.id_imm_src    = imm_src;
  assign pc.ex_alu_ctrl   = ex_c.alu_ctrl;
  assign pc.ex_alu_src    = ex_c.alu_src;
  assign pc.ex_unsigned   = ex_c.is_unsigned;
  assign pc.ex_lui        = ex_c.lui;
  assign pc.ex_branch     = ex_c.branch;
  assign pc.ex_jump       = ex_c.jump;
  assign pc.mem_mem_write = mem_mw;
  assign pc.wb_reg_write  = wb_rw;
  assign pc.wb_result_src = wb_rs;
  assign pc.wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: a decode vector table checked through a stage
// scoreboard, plus hand sequences for load-use, forwarding, redirect, x0 and reset.
module tb_pipe_controller;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_J = 7'b1101111,
                         OP_JR = 7'b1100111, OP_U = 7'b0110111, OP_NOP = 7'b0000000;

  logic clk;
  logic rst_n;

  pipe_controller_if #(.REG_AW(5)) b0();
  pipe_controller_if #(.REG_AW(5)) b1();

  pipe_controller #(.REG_AW(5), .FWD_EN(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .pc(b0));
  pipe_controller #(.REG_AW(5), .FWD_EN(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .pc(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7;
    logic [2:0] imm; logic [2:0] alu; logic src; logic uns; logic lui;
    logic [1:0] br; logic [1:0] jmp; logic mw; logic rw; logic [1:0] rs;
  } vec_t;

  typedef struct packed {
    logic [2:0] alu; logic src; logic uns; logic lui;
    logic [1:0] br; logic [1:0] jmp; logic mw; logic rw; logic [1:0] rs; logic [4:0] rd;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t s_ex, s_mem, s_wb, e;
  bit   sb_on;
  int   n_cmp, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic pcs);
    b0.id_op = op; b0.id_funct3 = f3; b0.id_funct7 = f7;
    b0.id_rs1 = r1; b0.id_rs2 = r2; b0.id_rd = rd; b0.ex_pc_src = pcs;
    b1.id_op = op; b1.id_funct3 = f3; b1.id_funct7 = f7;
    b1.id_rs1 = r1; b1.id_rs2 = r2; b1.id_rd = rd; b1.ex_pc_src = pcs;
    #1;
  endtask

  // one clock; with the scoreboard on, shift expected records and compare stage outputs
  task automatic tick();
    @(posedge clk);
    #2;
    if (sb_on) begin
      s_wb  = s_mem;
      s_mem = s_ex;
      s_ex  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("ex_alu_ctrl",   b0.ex_alu_ctrl,   s_ex.alu);
      chk("ex_alu_src",    b0.ex_alu_src,    s_ex.src);
      chk("ex_unsigned",   b0.ex_unsigned,   s_ex.uns);
      chk("ex_lui",        b0.ex_lui,        s_ex.lui);
      chk("ex_branch",     b0.ex_branch,     s_ex.br);
      chk("ex_jump",       b0.ex_jump,       s_ex.jmp);
      chk("mem_mem_write", b0.mem_mem_write, s_mem.mw);
      chk("wb_reg_write",  b0.wb_reg_write,  s_wb.rw);
      chk("wb_result_src", b0.wb_result_src, s_wb.rs);
      chk("wb_rd",         b0.wb_rd,         s_wb.rd);
      chk("fwd_a_tbl",     b0.fwd_a,         2'b00);
    end
  endtask

  task automatic flush();
    drive(OP_NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    int   cnt;
    logic [1:0] fa0, fb0;
    n_cmp = 0; n_bad = 0; sb_on = 0;
    s_ex = '0; s_mem = '0; s_wb = '0;

    //       op     f3      f7    imm     alu     src  uns  lui  br     jmp    mw   rw   rs
    vecs.push_back('{OP_R, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});
    vecs.push_back('{OP_R, 3'b000, 1'b1, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});
    vecs.push_back('{OP_R, 3'b001, 1'b0, 3'b000, 3'b110, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});
    vecs.push_back('{OP_R, 3'b010, 1'b0, 3'b000, 3'b101, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});
    vecs.push_back('{OP_R, 3'b011, 1'b0, 3'b000, 3'b101, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});
    vecs.push_back('{OP_R, 3'b100, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});
    vecs.push_back('{OP_R, 3'b101, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});
    vecs.push_back('{OP_R, 3'b110, 1'b0, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});
    vecs.push_back('{OP_R, 3'b111, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});
    vecs.push_back('{OP_I, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});
    vecs.push_back('{OP_I, 3'b011, 1'b0, 3'b000, 3'b101, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});
    vecs.push_back('{OP_L, 3'b010, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01});
    vecs.push_back('{OP_S, 3'b010, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00});
    vecs.push_back('{OP_B, 3'b000, 1'b0, 3'b010, 3'b001, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00});
    vecs.push_back('{OP_B, 3'b001, 1'b0, 3'b010, 3'b001, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00});
    vecs.push_back('{OP_B, 3'b100, 1'b0, 3'b010, 3'b001, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00});
    vecs.push_back('{OP_B, 3'b110, 1'b0, 3'b010, 3'b001, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00});
    vecs.push_back('{OP_J, 3'b000, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 2'b10});
    vecs.push_back('{OP_JR,3'b000, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 2'b10});
    vecs.push_back('{OP_U, 3'b000, 1'b0, 3'b100, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00});

    // reset state
    rst_n = 1'b1;
    drive(OP_NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("rst_ex_alu_src",    b0.ex_alu_src,    1'b0);
    chk("rst_mem_mem_write", b0.mem_mem_write, 1'b0);
    chk("rst_wb_reg_write",  b0.wb_reg_write,  1'b0);
    chk("rst_wb_rd",         b0.wb_rd,         5'd0);
    chk("rst_fwd",           {b0.fwd_a, b0.fwd_b}, 4'b0000);
    chk("rst_hazard",        {b0.stall_f, b0.stall_d, b0.flush_d, b0.flush_e}, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // decode table through the stage scoreboard; sources are x0 so no hazards arise
    sb_on = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, 5'd0, 5'd0, 5'(i + 1), 1'b0);
      chk("id_imm_src", b0.id_imm_src, vecs[i].imm);
      chk("tbl_stall",  {b0.stall_f, b0.flush_e, b1.stall_f}, 3'b000);
      e = '{alu: vecs[i].alu, src: vecs[i].src, uns: vecs[i].uns, lui: vecs[i].lui,
            br: vecs[i].br, jmp: vecs[i].jmp, mw: vecs[i].mw, rw: vecs[i].rw,
            rs: vecs[i].rs, rd: 5'(i + 1)};
      exp_q.push_back(e);
      tick();
    end
    drive(OP_NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (3) begin
      exp_q.push_back('0);
      tick();
    end
    sb_on = 0;

    // load-use: lw x5 ; add x6,x5,x1
    drive(OP_L, 3'b010, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0);
    tick();
    drive(OP_R, 3'b000, 1'b0, 5'd5, 5'd1, 5'd6, 1'b0);
    chk("lu_stall", {b0.stall_f, b0.stall_d, b0.flush_e, b0.flush_d}, 4'b1110);
    tick();
    chk("lu_one_cycle", {b0.stall_f, b0.stall_d, b0.flush_e}, 3'b000);
    chk("lu_bubble_src", b0.ex_alu_src, 1'b0);
    tick();
    chk("lu_fwd_a", b0.fwd_a, 2'b01);
    chk("lu_fwd_b", b0.fwd_b, 2'b00);
    flush();

    // add x7 ; sub x8,x7,x7 : forward on dut0, three stalls on dut1
    drive(OP_R, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0);
    tick();
    drive(OP_R, 3'b000, 1'b1, 5'd7, 5'd7, 5'd8, 1'b0);
    chk("raw_nostall_fwd", b0.stall_f, 1'b0);
    chk("raw_stall_nofwd", {b1.stall_f, b1.stall_d, b1.flush_e}, 3'b111);
    cnt = 0; fa0 = 2'bxx; fb0 = 2'bxx;
    for (int g = 0; g < 8 && b1.stall_f; g++) begin
      cnt++;
      chk("nofwd_fwd_zero", {b1.fwd_a, b1.fwd_b}, 4'b0000);
      tick();
      if (g == 0) begin fa0 = b0.fwd_a; fb0 = b0.fwd_b; end
    end
    chk("raw_fwd_a", fa0, 2'b10);
    chk("raw_fwd_b", fb0, 2'b10);
    chk("nofwd_stall_cnt", cnt, 3);
    tick();
    chk("nofwd_sub_in_ex", b1.ex_alu_ctrl, 3'b001);
    chk("nofwd_fwd_ex", {b1.fwd_a, b1.fwd_b}, 4'b0000);
    flush();

    // x0 writer then x0 reader: no forward, no stall
    drive(OP_I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(OP_R, 3'b000, 1'b0, 5'd0, 5'd0, 5'd9, 1'b0);
    chk("x0_stall", {b0.stall_f, b1.stall_f, b0.flush_e}, 3'b000);
    tick();
    chk("x0_fwd", {b0.fwd_a, b0.fwd_b}, 4'b0000);
    drive(OP_L, 3'b010, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(OP_R, 3'b000, 1'b0, 5'd0, 5'd0, 5'd9, 1'b0);
    chk("x0_load_stall", b0.stall_f, 1'b0);
    flush();

    // redirect in the same cycle as a load-use hazard
    drive(OP_L, 3'b010, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0);
    tick();
    drive(OP_S, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 1'b1);
    chk("redir_ctl", {b0.flush_d, b0.flush_e, b0.stall_f, b0.stall_d}, 4'b1100);
    tick();
    drive(OP_NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("redir_ex_bubble", b0.ex_alu_src, 1'b0);
    tick();
    chk("redir_mem_write", b0.mem_mem_write, 1'b0);
    chk("redir_lw_wb", {b0.wb_reg_write, b0.wb_rd}, {1'b1, 5'd5});
    tick();
    chk("redir_wb_write", {b0.wb_reg_write, b0.wb_rd}, 6'd0);
    flush();

    // reset mid-stream
    drive(OP_S, 3'b010, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(OP_L, 3'b010, 1'b0, 5'd0, 5'd0, 5'd4, 1'b0);
    tick();
    drive(OP_R, 3'b000, 1'b0, 5'd0, 5'd0, 5'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ex", {b0.ex_alu_src, b0.ex_alu_ctrl, b0.ex_branch, b0.ex_jump}, 8'd0);
    chk("mid_rst_mem_wb", {b0.mem_mem_write, b0.wb_reg_write, b0.wb_result_src, b0.wb_rd}, 9'd0);
    chk("mid_rst_hz", {b0.fwd_a, b0.fwd_b, b0.stall_f, b0.flush_e}, 6'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_wb0", b0.wb_reg_write, 1'b0);
    drive(OP_NOP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    chk("post_rst_wb1", b0.wb_reg_write, 1'b0);
    tick();
    chk("post_rst_wb3", {b0.wb_reg_write, b0.wb_rd}, {1'b1, 5'd3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
